muldiv_ctrl: RTL and testbench

- Sequences the shared multiplier and divider for the execute stage and owns the architectural HI/LO registers.
- Accepts one muldiv-class operation per handshake: MULT, DIV, MTHI, MTLO, MFHI, MFLO.
- Stalls the pipeline while an operation is in flight.
- Abandons in-flight work on exception/flush via cancel.

---
 rtl/muldiv_ctrl_if.sv | 22 ++
 rtl/muldiv_ctrl.sv | 110 +++++++++++
 tb/tb_muldiv_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: execute-stage issue/response bundle for muldiv_ctrl
interface muldiv_ctrl_if;
  logic        issue_valid;
  logic [3:0]  issue_op;
  logic        issue_signed;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        issue_ready;
  logic [31:0] mf_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  modport master (
    output issue_valid, issue_op, issue_signed, src_a, src_b, cancel,
    input  issue_ready, mf_data, hi, lo, busy
  );
  modport slave (
    input  issue_valid, issue_op, issue_signed, src_a, src_b, cancel,
    output issue_ready, mf_data, hi, lo, busy
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences shared mul/div and owns HI/LO; define MULDIV_MADD_EN to enable MADD/MSUB
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  muldiv_ctrl_if.slave      ex,
  output logic [31:0]       mul_x,
  output logic [31:0]       mul_y,
  output logic              mul_signed,
  input  logic [63:0]       mul_res,
  output logic              div_start,
  output logic              div_cancel,
  output logic [31:0]       div_x,
  output logic [31:0]       div_y,
  output logic              div_signed,
  input  logic [31:0]       div_s,
  input  logic [31:0]       div_r,
  input  logic              div_complete
);
  localparam logic [3:0] OP_MULT = 4'd1;
  localparam logic [3:0] OP_DIV  = 4'd2;
  localparam logic [3:0] OP_MTHI = 4'd3;
  localparam logic [3:0] OP_MTLO = 4'd4;
  localparam logic [3:0] OP_MFHI = 4'd5;
  localparam logic [3:0] OP_MFLO = 4'd6;
`ifdef MULDIV_MADD_EN
  localparam logic [3:0] OP_MADD = 4'd7;
  localparam logic [3:0] OP_MSUB = 4'd8;
  localparam logic [3:0] OP_MAX  = 4'd8;
`else
  localparam logic [3:0] OP_MAX  = 4'd6;
`endif
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        nop;
  logic        fire;
  logic        mul_done;
  logic        to_mul;
  logic [63:0] mul_wr;
`ifdef MULDIV_MADD_EN
  logic        acc;
  logic        sub;
`endif
  // handshake, operand fan-out and the value written back when the multiply finishes
  always_comb begin
    nop            = ex.issue_op == 4'd0 || ex.issue_op > OP_MAX;
    ex.issue_ready = !ex.cancel && (state == IDLE || nop);
    fire           = ex.issue_valid && ex.issue_ready;
    ex.busy        = state != IDLE;
    ex.hi          = hi_q;
    ex.lo          = lo_q;
    ex.mf_data     = ex.issue_op == OP_MFHI ? hi_q : ex.issue_op == OP_MFLO ? lo_q : '0;
    div_start      = fire && state == IDLE && ex.issue_op == OP_DIV;
    div_cancel     = state == DIV && ex.cancel;
    mul_done       = state == MUL && cnt == 3'(MUL_LAT - 1);
    mul_x          = ex.src_a;
    mul_y          = ex.src_b;
    mul_signed     = ex.issue_signed;
    div_x          = ex.src_a;
    div_y          = ex.src_b;
    div_signed     = ex.issue_signed;
`ifdef MULDIV_MADD_EN
    to_mul         = ex.issue_op == OP_MULT || ex.issue_op == OP_MADD || ex.issue_op == OP_MSUB;
    mul_wr         = !acc ? mul_res : sub ? {hi_q, lo_q} - mul_res : {hi_q, lo_q} + mul_res;
`else
    to_mul         = ex.issue_op == OP_MULT;
    mul_wr         = mul_res;
`endif
  end
  // sequencer: cancel beats any completion, so HI/LO are only written by an uncancelled op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef MULDIV_MADD_EN
      acc   <= 1'b0;
      sub   <= 1'b0;
`endif
    end else if (ex.cancel) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (fire) begin
        state <= to_mul ? MUL : ex.issue_op == OP_DIV ? DIV : IDLE;
        cnt   <= '0;
        hi_q  <= ex.issue_op == OP_MTHI ? ex.src_a : hi_q;
        lo_q  <= ex.issue_op == OP_MTLO ? ex.src_a : lo_q;
`ifdef MULDIV_MADD_EN
        acc   <= ex.issue_op == OP_MADD || ex.issue_op == OP_MSUB;
        sub   <= ex.issue_op == OP_MSUB;
`endif
      end
    end else if (state == MUL) begin
      cnt   <= cnt + 3'd1;
      state <= mul_done ? IDLE : MUL;
      if (mul_done)
        {hi_q, lo_q} <= mul_wr;
    end else if (div_complete) begin
      hi_q  <= div_r;
      lo_q  <= div_s;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: scoreboard bench for muldiv_ctrl with a model multiplier pipeline
module tb_muldiv_ctrl;
  localparam int LAT = 2;
  logic        clk = 0;
  logic        reset = 1;
  logic [31:0] mul_x, mul_y, div_x, div_y;
  logic        mul_signed, div_start, div_cancel, div_signed;
  logic [63:0] mul_res, prod;
  logic [63:0] pipe [LAT];
  logic [31:0] div_s = 0, div_r = 0;
  logic        div_complete = 0;
  logic        rdq [$];
  logic [31:0] mfq [$];
  logic [64:0] dsq [$];
  int          dcq [$];
  logic [95:0] bq [$];
  logic [95:0] be;
  int          checks = 0, errors = 0, blen = 0;
  bit          pb = 0, done = 0;

  always #5 clk = ~clk;

  muldiv_ctrl_if ex();

  muldiv_ctrl #(.MUL_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .ex(ex),
    .mul_x(mul_x), .mul_y(mul_y), .mul_signed(mul_signed), .mul_res(mul_res),
    .div_start(div_start), .div_cancel(div_cancel), .div_x(div_x), .div_y(div_y),
    .div_signed(div_signed), .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
  );

  always_comb begin
    prod = mul_signed ? {{32{mul_x[31]}}, mul_x} * {{32{mul_y[31]}}, mul_y}
                      : {32'b0, mul_x} * {32'b0, mul_y};
    mul_res = pipe[LAT-1];
  end

  always @(posedge clk) begin
    pipe[0] <= prod;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end

  task automatic chk(input string n, input logic [95:0] a, input logic [95:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic unexpected(input string n);
    checks++;
    errors++;
    $display("FAIL %s: got an event expected none", n);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        chk("queues_drained", 96'(rdq.size() + mfq.size() + dsq.size() + dcq.size() + bq.size()), 96'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      if (reset) begin
        chk("reset_state", {ex.hi, ex.lo, ex.busy, div_start, div_cancel}, 96'd0);
        blen = 0;
        pb = 0;
      end else begin
        if (ex.issue_valid) begin
          if (rdq.size() == 0) unexpected("issue_ready");
          else chk("issue_ready", 96'(ex.issue_ready), 96'(rdq.pop_front()));
        end
        if (ex.issue_valid && ex.issue_ready && (ex.issue_op == 4'd5 || ex.issue_op == 4'd6)) begin
          if (mfq.size() == 0) unexpected("mf_data");
          else chk("mf_data", 96'(ex.mf_data), 96'(mfq.pop_front()));
        end
        if (div_start) begin
          if (dsq.size() == 0) unexpected("div_start");
          else chk("div_start_ops", 96'({div_x, div_y, div_signed}), 96'(dsq.pop_front()));
        end
        if (div_cancel) begin
          if (dcq.size() == 0) unexpected("div_cancel");
          else chk("div_cancel_busy", 96'(ex.busy), 96'(dcq.pop_front()));
        end
        if (ex.busy) blen++;
        else if (pb) begin
          if (bq.size() == 0) unexpected("busy_end");
          else begin
            be = bq.pop_front();
            chk("busy_len", 96'(blen), 96'(be[95:64]));
            chk("hi_lo", 96'({ex.hi, ex.lo}), 96'(be[63:0]));
          end
          blen = 0;
        end
        pb = ex.busy;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic sg, input logic [31:0] a, input logic [31:0] b, input logic rdy);
    ex.issue_valid = 1;
    ex.issue_op = op;
    ex.issue_signed = sg;
    ex.src_a = a;
    ex.src_b = b;
    rdq.push_back(rdy);
    step();
    ex.issue_valid = 0;
    ex.issue_op = 0;
  endtask

  task automatic mf(input logic [3:0] op, input logic [31:0] e);
    mfq.push_back(e);
    issue(op, 0, 0, 0, 1);
  endtask

  initial begin
    ex.issue_valid = 0;
    ex.issue_op = 0;
    ex.issue_signed = 0;
    ex.src_a = 0;
    ex.src_b = 0;
    ex.cancel = 0;
    repeat (2) step();
    reset = 0;
    step();
    bq.push_back({32'd2, 32'hFFFFFFFF, 32'hFFFFFFFA});
    issue(1, 1, 32'hFFFFFFFE, 32'd3, 1);
    issue(6, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 1);
    mf(6, 32'hFFFFFFFA);
    mf(5, 32'hFFFFFFFF);
    dsq.push_back({32'd100, 32'd7, 1'b0});
    bq.push_back({32'd33, 32'd2, 32'd14});
    issue(2, 0, 32'd100, 32'd7, 1);
    repeat (32) step();
    div_s = 32'd14;
    div_r = 32'd2;
    div_complete = 1;
    step();
    div_complete = 0;
    mf(5, 32'd2);
    mf(6, 32'd14);
    issue(3, 0, 32'h11111111, 0, 1);
    issue(4, 0, 32'h22222222, 0, 1);
    dsq.push_back({32'hFFFFFFF7, 32'd2, 1'b1});
    bq.push_back({32'd9, 32'h11111111, 32'h22222222});
    dcq.push_back(1);
    issue(2, 1, 32'hFFFFFFF7, 32'd2, 1);
    repeat (8) step();
    ex.cancel = 1;
    ex.issue_valid = 1;
    ex.issue_op = 5;
    rdq.push_back(0);
    step();
    ex.cancel = 0;
    ex.issue_valid = 0;
    ex.issue_op = 0;
    step();
    div_s = 32'hDEAD;
    div_r = 32'hBEEF;
    div_complete = 1;
    step();
    div_complete = 0;
    mf(5, 32'h11111111);
    mf(6, 32'h22222222);
    issue(3, 0, 32'hDEADBEEF, 0, 1);
    mf(5, 32'hDEADBEEF);
    issue(4, 0, 32'h12345678, 0, 1);
    mf(5, 32'hDEADBEEF);
    mf(6, 32'h12345678);
    dsq.push_back({32'd5, 32'd1, 1'b0});
    bq.push_back({32'd4, 32'hDEADBEEF, 32'h12345678});
    dcq.push_back(1);
    issue(2, 0, 32'd5, 32'd1, 1);
    repeat (3) step();
    ex.cancel = 1;
    div_s = 32'd5;
    div_r = 32'd0;
    div_complete = 1;
    step();
    ex.cancel = 0;
    div_complete = 0;
    mf(5, 32'hDEADBEEF);
    mf(6, 32'h12345678);
    bq.push_back({32'd2, 32'hDEADBEEF, 32'h12345678});
    issue(1, 0, 32'd3, 32'd4, 1);
    step();
    ex.cancel = 1;
    step();
    ex.cancel = 0;
    mf(6, 32'h12345678);
    bq.push_back({32'd2, 32'hFFFFFFFE, 32'h00000001});
    issue(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    repeat (2) step();
    mf(5, 32'hFFFFFFFE);
    mf(6, 32'h00000001);
    issue(3, 0, 32'h0, 0, 1);
    issue(4, 0, 32'hFFFFFFFF, 0, 1);
`ifdef MULDIV_MADD_EN
    bq.push_back({32'd2, 32'd1, 32'd0});
    issue(7, 0, 32'd1, 32'd1, 1);
    repeat (2) step();
    mf(5, 32'd1);
    mf(6, 32'd0);
    bq.push_back({32'd2, 32'd0, 32'hFFFFFFFE});
    issue(8, 0, 32'd1, 32'd2, 1);
    repeat (2) step();
    mf(5, 32'd0);
    mf(6, 32'hFFFFFFFE);
`else
    issue(7, 0, 32'd1, 32'd1, 1);
    repeat (2) step();
    mf(5, 32'd0);
    mf(6, 32'hFFFFFFFF);
    issue(8, 0, 32'd1, 32'd2, 1);
    repeat (2) step();
    mf(5, 32'd0);
    mf(6, 32'hFFFFFFFF);
`endif
    issue(1, 0, 32'd2, 32'd3, 1);
    reset = 1;
    step();
    reset = 0;
    step();
    mf(5, 32'd0);
    mf(6, 32'd0);
    repeat (3) step();
    done = 1;
  end
endmodule
